irq_controller: RTL and testbench
=================================

# irq_controller

Prioritised interrupt controller that sits between peripheral interrupt sources and the CPU control path. It edge-detects up to `N_SRC` source lines, latches them as pending, applies a per-source mask and a global enable, and presents one request (`irq`) plus its handler address (`irq_vector`) to the control path. It holds that request until the control path acknowledges it with its `reset_irq` pulse, issued in the control path's IRQ-reset state.

## Interface
- `N_SRC`, 8: number of interrupt sources, 2..16.
- `VECTOR_BASE`, 16'hFF00: handler address of source 0.
- `VECTOR_STRIDE`, 16'h0010: address spacing between consecutive source handlers.

- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `src` in N_SRC: interrupt source lines, synchronous to `clock`, rising-edge triggered.
- `irq_enable` in 1: global enable; when low, no new request is issued.
- `mask_we` in 1: write strobe for the mask register.
- `mask_wdata` in N_SRC: new mask value; bit=1 masks that source.
- `reset_irq` in 1: acknowledge from the control path, a 1-cycle pulse.
- `irq` out 1: interrupt request to the control path.
- `irq_vector` out 16: handler address of the request in service.
- `irq_id` out clog2(N_SRC): index of the request in service.
- `pending` out N_SRC: pending register, for debug and status readback.
- `mask` out N_SRC: current mask register.

## Operation
- **Edge detect:** `src_q` is a per-bit register of `src`. `edge = src & ~src_q`. `src_q` resets to 0, so a line that is already high in the first cycle after reset counts as one edge.
- **Pending:** `pending[i]` is set on `edge[i]`. It clears only on acknowledge of source `i`. If set and clear coincide on the same bit, set wins and the bit stays 1.
- **Mask:** `mask` is loaded from `mask_wdata` when `mask_we` is high. Masking does not clear `pending`. Unmasking a source with a pending bit makes it eligible the next cycle.
- **Eligibility and priority:** `eligible = pending & ~mask`, gated by `irq_enable`. The lowest index has the highest priority (fixed priority).
- **FSM states:** S_IDLE, S_REQ, S_GAP.
  - **S_IDLE:** if any bit of `eligible` is set, latch `sel` = lowest eligible index, go to S_REQ. Otherwise stay in S_IDLE.
  - **S_REQ:** `irq=1`. `irq_id=sel`. `irq_vector = VECTOR_BASE + sel*VECTOR_STRIDE`, truncated to 16 bits (wrap-around allowed). On `reset_irq`: clear `pending[sel]` (unless a new edge on `sel` in that cycle), go to S_GAP. While in S_REQ, mask writes, `irq_enable` falling, and new higher-priority edges do not withdraw or change the request; `sel` is frozen.
  - **S_GAP:** `irq=0` for one cycle, so the control path sees a deasserted line before its next IRQ sample. Then go to S_IDLE.
- `reset_irq` outside S_REQ is ignored; no state or pending change.
- `irq`, `irq_id` and `irq_vector` are registered outputs, decoded from FSM state and `sel`. `irq_vector` and `irq_id` hold their last value outside S_REQ.
- **Reset values:** state=S_IDLE, `irq=0`, `irq_id=0`, `irq_vector=VECTOR_BASE`, `pending=0`, `mask` all ones (all masked), `src_q=0`.
- A reset asserted in any state, including mid-request, returns all registers to their reset values on that edge. No acknowledge is required.

## Timing
- **Source edge to pending:** `src` high at edge t with `src_q` low gives `pending` set after edge t.
- **Pending to request:** `irq` goes high after edge t+1, if the source is eligible at t+1. Total latency from `src` rising is 2 clocks.
- **Acknowledge:** `reset_irq` sampled high at edge a gives `irq` low after edge a and the pending bit clear after edge a. The earliest next `irq` rise is after edge a+2.
- `irq_vector` and `irq_id` are stable for the entire time `irq` is high.
- A mask write at edge m takes effect for the eligibility check at edge m+1.

## Test plan
- **Single source:** after reset, write mask=8'h00 and pulse `src[3]`. Required: `irq` high 2 cycles later, `irq_vector=16'hFF30`, `irq_id=3`. Then pulse `reset_irq`. Required: `irq` low the next cycle, `pending=0`.
- **Priority:** edges on `src[5]` and `src[1]` in the same cycle. Required: first request `irq_vector=16'hFF10`. After ack and the one-cycle gap, second request `irq_vector=16'hFF50`.
- **Mask behaviour:** with mask=8'h04, pulse `src[2]`. Required: `pending=8'h04`, `irq` stays 0. Write mask=8'h00. Required: `irq` high 2 cycles after the write.
- **Set-wins on ack:** hold S_REQ for source 0 and apply a new `src[0]` edge in the same cycle as `reset_irq`. Required: `pending[0]` stays 1, and a second request for source 0 follows after S_GAP.
- **Reset mid-request:** assert `reset` while `irq=1`. Required: the next cycle has `irq=0`, `pending=0`, `mask=8'hFF`, `irq_vector=16'hFF00`.
- **Ignored acknowledge and enable:** pulse `reset_irq` in S_IDLE. Required: no change. With `irq_enable=0` and `pending=8'h01`, `irq` stays 0. Raise `irq_enable`. Required: `irq` high the next cycle.

Source files
------------

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge-detects sources, latches them as pending, and
// presents one masked, fixed-priority request with its vector until acknowledged.
module irq_controller #(
    parameter int unsigned N_SRC         = 8,
    parameter logic [15:0] VECTOR_BASE   = 16'hFF00,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0010,
    localparam int unsigned IdW          = $clog2(N_SRC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             irq_enable,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             reset_irq,
    output logic             irq,
    output logic [15:0]      irq_vector,
    output logic [IdW-1:0]   irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   src_q, src_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [IdW-1:0]     sel_q, sel_d;
    logic               irq_q, irq_d;
    logic [15:0]        vec_q, vec_d;

    logic [N_SRC-1:0]   src_rise;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   clr;
    logic [IdW-1:0]     pick;
    logic               found;
    logic               ack;

    always_comb begin
        src_d    = src;
        src_rise = src & ~src_q;
        eligible = pending_q & ~mask_q & {N_SRC{irq_enable}};

        // Scan downward so the lowest eligible index wins.
        pick  = '0;
        found = 1'b0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                pick  = IdW'(i);
            end
        end

        ack = (state_q == StReq) && reset_irq;
        for (int i = 0; i < int'(N_SRC); i++) begin
            clr[i] = ack && (sel_q == IdW'(i));
        end

        // A new edge on the acknowledged source keeps its pending bit set.
        pending_d = (pending_q & ~clr) | src_rise;
        mask_d    = mask_we ? mask_wdata : mask_q;

        state_d = state_q;
        sel_d   = sel_q;
        irq_d   = irq_q;
        vec_d   = vec_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StReq;
                    sel_d   = pick;
                    irq_d   = 1'b1;
                    vec_d   = VECTOR_BASE + 16'(pick) * VECTOR_STRIDE;
                end
            end
            StReq: begin
                if (reset_irq) begin
                    state_d = StGap;
                    irq_d   = 1'b0;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            sel_q     <= '0;
            irq_q     <= 1'b0;
            vec_q     <= VECTOR_BASE;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            sel_q     <= sel_d;
            irq_q     <= irq_d;
            vec_q     <= vec_d;
        end
    end

    assign irq        = irq_q;
    assign irq_vector = vec_q;
    assign irq_id     = sel_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected requests go into a scoreboard queue that a
// monitor drains on every rising irq; register state is checked inline at fixed cycles.
module tb_irq_controller;

    logic        clock;
    logic        reset;
    logic [7:0]  src;
    logic        irq_enable;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        reset_irq;
    logic        irq;
    logic [15:0] irq_vector;
    logic [2:0]  irq_id;
    logic [7:0]  pending;
    logic [7:0]  mask;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] vec;
        logic [2:0]  id;
    } exp_t;

    exp_t sb[$];

    irq_controller #(
        .N_SRC        (8),
        .VECTOR_BASE  (16'hFF00),
        .VECTOR_STRIDE(16'h0010)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .src       (src),
        .irq_enable(irq_enable),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .reset_irq (reset_irq),
        .irq       (irq),
        .irq_vector(irq_vector),
        .irq_id    (irq_id),
        .pending   (pending),
        .mask      (mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_req(input logic [15:0] vec, input logic [2:0] id);
        exp_t e;
        e.vec = vec;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic ack();
        reset_irq = 1'b1;
        tick();
        reset_irq = 1'b0;
    endtask

    // Monitor: pop one expectation per rising irq; vector must stay put while irq is high.
    logic        irq_prev = 1'b0;
    logic [15:0] vec_hold = '0;
    always @(negedge clock) begin
        if (irq && !irq_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_irq: got vector %0h with empty scoreboard", irq_vector);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_vector", 32'(irq_vector), 32'(e.vec));
                check("sb_id", 32'(irq_id), 32'(e.id));
            end
            vec_hold = irq_vector;
        end else if (irq && irq_prev) begin
            check("vector_stable", 32'(irq_vector), 32'(vec_hold));
        end
        irq_prev = irq;
    end

    initial begin
        reset      = 1'b1;
        src        = '0;
        irq_enable = 1'b1;
        mask_we    = 1'b0;
        mask_wdata = '0;
        reset_irq  = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_mask", 32'(mask), 32'hFF);
        check("rst_vector", 32'(irq_vector), 32'hFF00);
        check("rst_id", 32'(irq_id), 32'd0);

        // Single source
        mask_we = 1'b1; mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        check("unmask_all", 32'(mask), 32'h00);
        src = 8'h08;
        expect_req(16'hFF30, 3'd3);
        tick();
        src = 8'h00;
        check("single_pending", 32'(pending), 32'h08);
        check("single_irq_lat1", 32'(irq), 32'd0);
        tick();
        check("single_irq", 32'(irq), 32'd1);
        check("single_vector", 32'(irq_vector), 32'hFF30);
        ack();
        check("single_ack_irq", 32'(irq), 32'd0);
        check("single_ack_pending", 32'(pending), 32'h00);
        tick();

        // Priority
        src = 8'h22;
        expect_req(16'hFF10, 3'd1);
        expect_req(16'hFF50, 3'd5);
        tick();
        src = 8'h00;
        tick();
        check("prio_first_vec", 32'(irq_vector), 32'hFF10);
        ack();
        check("prio_gap_irq", 32'(irq), 32'd0);
        check("prio_pending", 32'(pending), 32'h20);
        tick();
        check("prio_idle_irq", 32'(irq), 32'd0);
        tick();
        check("prio_second_irq", 32'(irq), 32'd1);
        check("prio_second_vec", 32'(irq_vector), 32'hFF50);
        ack();
        tick();
        check("prio_done_pending", 32'(pending), 32'h00);

        // Mask behaviour
        mask_we = 1'b1; mask_wdata = 8'h04;
        tick();
        mask_we = 1'b0;
        src = 8'h04;
        tick();
        src = 8'h00;
        check("mask_pending", 32'(pending), 32'h04);
        tick();
        tick();
        check("masked_irq", 32'(irq), 32'd0);
        mask_we = 1'b1; mask_wdata = 8'h00;
        expect_req(16'hFF20, 3'd2);
        tick();
        mask_we = 1'b0;
        check("unmask_irq_lat1", 32'(irq), 32'd0);
        tick();
        check("unmask_irq", 32'(irq), 32'd1);
        ack();
        tick();

        // Set wins over clear on ack
        src = 8'h01;
        expect_req(16'hFF00, 3'd0);
        tick();
        src = 8'h00;
        tick();
        check("setwin_irq", 32'(irq), 32'd1);
        src = 8'h01;
        expect_req(16'hFF00, 3'd0);
        ack();
        src = 8'h00;
        check("setwin_pending", 32'(pending), 32'h01);
        check("setwin_gap_irq", 32'(irq), 32'd0);
        tick();
        tick();
        check("setwin_second_irq", 32'(irq), 32'd1);
        check("setwin_second_id", 32'(irq_id), 32'd0);

        // Reset mid-request
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_pending", 32'(pending), 32'h00);
        check("midrst_mask", 32'(mask), 32'hFF);
        check("midrst_vector", 32'(irq_vector), 32'hFF00);

        // Ignored ack and global enable
        mask_we = 1'b1; mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        irq_enable = 1'b0;
        ack();
        check("idle_ack_irq", 32'(irq), 32'd0);
        check("idle_ack_pending", 32'(pending), 32'h00);
        src = 8'h01;
        tick();
        src = 8'h00;
        check("en_pending", 32'(pending), 32'h01);
        tick();
        tick();
        check("disabled_irq", 32'(irq), 32'd0);
        irq_enable = 1'b1;
        expect_req(16'hFF00, 3'd0);
        tick();
        check("enabled_irq", 32'(irq), 32'd1);
        ack();
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
